// File: rtl/ncc_pkg.sv
// Shared types and log-domain helpers for the NCC correlator array.
// The log helpers are used only when NCC_LOG_MULT_EN is defined.
package ncc_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} ncc_state_e;

  // 5.27 fixed-point base-2 logarithm
  typedef logic [31:0] log_fix_t;

  localparam int LOG_FRAC_W = 27;

  // Leading-one position gives the integer part. The bits below the leading
  // one, left-aligned, give a linear (Mitchell) estimate of the fraction.
  // This is exact for powers of two. x == 0 is the caller's responsibility.
  function automatic log_fix_t log2_fix(input logic [31:0] x);
    logic [4:0] msb;
    msb = '0;
    for (int i = 0; i < 32; i++) begin
      if (x[i]) msb = 5'(i);
    end
    return ({27'b0, msb} << LOG_FRAC_W) |
           (((x << (5'd31 - msb)) >> 4) & 32'h07FF_FFFF);
  endfunction

  // Inverse of log2_fix. Computes (1.frac) << int, with the fraction truncated.
  function automatic logic [31:0] ilog2_fix(input log_fix_t l);
    return 32'(({36'b0, 1'b1, l[LOG_FRAC_W-1:0]} << l[31:LOG_FRAC_W]) >> LOG_FRAC_W);
  endfunction

endpackage

// File: rtl/ncc_corr_array_if.sv
// Descriptor-load, window-stream and score handshakes of the NCC correlator.
// master = upstream/downstream environment, slave = ncc_corr_array.
interface ncc_corr_array_if #(
  parameter int ROWS  = 16,
  parameter int PIX_W = 8,
  parameter int LANES = 4,
  parameter int ACC_W = 24
);
  logic                     desc_start;
  logic                     desc_valid;
  logic                     desc_ready;
  logic [LANES*PIX_W-1:0]   desc_data;
  logic                     win_valid;
  logic                     win_ready;
  logic [ROWS*PIX_W-1:0]    win_data;
  logic                     score_valid;
  logic                     score_ready;
  logic signed [ACC_W-1:0]  score;
  logic                     loaded;

  modport master (
    output desc_start, desc_valid, desc_data, win_valid, win_data, score_ready,
    input  desc_ready, win_ready, score_valid, score, loaded
  );

  modport slave (
    input  desc_start, desc_valid, desc_data, win_valid, win_data, score_ready,
    output desc_ready, win_ready, score_valid, score, loaded
  );
endinterface

// File: rtl/ncc_pe.sv
// One correlator processing element. It holds a descriptor pixel and one
// window-chain tap, and registers the product of its descriptor pixel with
// the mirrored window tap. Define NCC_LOG_MULT_EN to use the log-domain
// approximate multiplier instead of the exact multiply.
module ncc_pe
  import ncc_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      d_load,
  input  logic signed [PIX_W-1:0]   d_in,
  input  logic                      w_shift,
  input  logic [PIX_W-1:0]          w_in,
  output logic [PIX_W-1:0]          w_q,
  input  logic                      p_en,
  input  logic [PIX_W-1:0]          w_mul,
  output logic signed [2*PIX_W:0]   p
);
  localparam int PW = 2*PIX_W + 1;

  logic signed [PIX_W-1:0] d_q;
  logic signed [PW-1:0]    prod;

`ifdef NCC_LOG_MULT_EN
  logic [PIX_W-1:0] mag_d;
  logic [31:0]      mag_p;

  // Log-domain product: sign(d) * 2^(log2|d| + log2 w), zero if either operand is zero
  always_comb begin
    // NOTE: every variable gets a default first so that no path can infer a latch.
    mag_d = d_q[PIX_W-1] ? PIX_W'(-d_q) : d_q;
    mag_p = '0;
    prod  = '0;
    if (d_q != '0 && w_mul != '0) begin
      mag_p = ilog2_fix(log2_fix(32'(mag_d)) + log2_fix(32'(w_mul)));
      prod  = d_q[PIX_W-1] ? -$signed(PW'(mag_p)) : $signed(PW'(mag_p));
    end
  end
`else
  // Exact signed x unsigned product (window pixel zero-extended to stay positive)
  always_comb begin
    prod = d_q * $signed({1'b0, w_mul});
  end
`endif

  // Descriptor load, window shift and product stage registers
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every register, including the descriptor and window storage, is cleared
    // so that a reset leaves no stale descriptor visible.
    if (rst) begin
      d_q <= '0;
      w_q <= '0;
      p   <= '0;
    end else begin
      // NOTE: non-blocking assignments, so neighbours in the chain read the pre-edge values.
      if (d_load)  d_q <= d_in;
      if (w_shift) w_q <= w_in;
      if (p_en)    p   <= prod;
    end
  end

endmodule

// File: rtl/ncc_corr_array.sv
// ROWS x COLS normalised-cross-correlation array. A descriptor is loaded
// LANES pixels per beat. Window columns then stream in, and one score is
// produced per window position through a three-stage pipeline
// (products, row sums, total). Define NCC_LOG_MULT_EN to select the
// log-domain multiplier in every PE. Latency is the same in both modes.
module ncc_corr_array
  import ncc_pkg::*;
#(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int PIX_W = 8,
  parameter int LANES = 4,
  parameter int ACC_W = 24
) (
  input logic               clk,
  input logic               rst,
  ncc_corr_array_if.slave   bus
);
  localparam int GRPS   = COLS / LANES;
  localparam int GRP_W  = (GRPS > 1) ? $clog2(GRPS) : 1;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FILL_W = $clog2(COLS + 1);
  localparam int PW     = 2*PIX_W + 1;

  ncc_state_e              state;
  logic [GRP_W-1:0]        grp_cnt;
  logic [ROW_W-1:0]        row_cnt;
  logic [FILL_W-1:0]       fill;
  logic                    v0, v1, v2;
  logic                    score_valid_q;
  logic signed [ACC_W-1:0] score_q;

  logic en, desc_ready_c, win_ready_c, desc_fire, win_fire, last_beat, scoring;

  logic signed [PW-1:0]    prod    [ROWS][COLS];
  logic [PIX_W-1:0]        wq      [ROWS][COLS];
  logic signed [ACC_W-1:0] row_sum_c [ROWS];
  logic signed [ACC_W-1:0] row_sum_q [ROWS];
  logic signed [ACC_W-1:0] total_c;

  // The whole pipeline freezes while a score waits for the downstream block
  assign en           = !score_valid_q || bus.score_ready;
  assign desc_ready_c = (state == LOAD) && !bus.desc_start;
  assign win_ready_c  = (state == RUN) && en && !bus.desc_start;
  assign desc_fire    = bus.desc_valid && desc_ready_c;
  assign win_fire     = bus.win_valid && win_ready_c;
  assign last_beat    = (row_cnt == ROW_W'(ROWS-1)) && (grp_cnt == GRP_W'(GRPS-1));
  // This beat completes (or keeps) a full COLS-wide window
  assign scoring      = win_fire && (fill >= FILL_W'(COLS-1));

  assign bus.desc_ready  = desc_ready_c;
  assign bus.win_ready   = win_ready_c;
  assign bus.score_valid = score_valid_q;
  assign bus.score       = score_q;
  assign bus.loaded      = (state == RUN);

  // Control FSM: descriptor beat position, window fill level and mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grp_cnt <= '0;
      row_cnt <= '0;
      fill    <= '0;
    end else if (bus.desc_start) begin
      state   <= LOAD;
      grp_cnt <= '0;
      row_cnt <= '0;
      fill    <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (desc_fire) begin
            if (last_beat) state <= RUN;
            if (grp_cnt == GRP_W'(GRPS-1)) begin
              grp_cnt <= '0;
              row_cnt <= last_beat ? '0 : row_cnt + 1'b1;
            end else begin
              grp_cnt <= grp_cnt + 1'b1;
            end
          end
        end
        RUN: begin
          if (win_fire && fill != FILL_W'(COLS)) fill <= fill + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // PE grid: each row is a window shift chain; PE (r,c) multiplies d[r][c] by tap COLS-1-c
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [PIX_W-1:0] w_src;
      if (c == 0) begin : g_head
        assign w_src = bus.win_data[r*PIX_W +: PIX_W];
      end else begin : g_link
        assign w_src = wq[r][c-1];
      end

      ncc_pe #(.PIX_W(PIX_W)) u_pe (
        .clk     (clk),
        .rst     (rst),
        .d_load  (desc_fire && (row_cnt == ROW_W'(r)) && (grp_cnt == GRP_W'(c / LANES))),
        .d_in    (bus.desc_data[(c % LANES)*PIX_W +: PIX_W]),
        .w_shift (win_fire),
        .w_in    (w_src),
        .w_q     (wq[r][c]),
        .p_en    (en),
        .w_mul   (wq[r][COLS-1-c]),
        .p       (prod[r][c])
      );
    end
  end

  // Row and total adder trees; products are sign-extended and wrap at ACC_W
  always_comb begin
    total_c = '0;
    for (int r = 0; r < ROWS; r++) begin
      row_sum_c[r] = '0;
      for (int c = 0; c < COLS; c++) begin
        row_sum_c[r] = row_sum_c[r] + ACC_W'(prod[r][c]);
      end
      total_c = total_c + row_sum_q[r];
    end
  end

  // Row-sum and score stages with their valid pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0            <= 1'b0;
      v1            <= 1'b0;
      v2            <= 1'b0;
      score_valid_q <= 1'b0;
      score_q       <= '0;
      for (int r = 0; r < ROWS; r++) row_sum_q[r] <= '0;
    end else if (bus.desc_start) begin
      v0            <= 1'b0;
      v1            <= 1'b0;
      v2            <= 1'b0;
      score_valid_q <= 1'b0;
    end else if (en) begin
      v0            <= scoring;
      v1            <= v0;
      v2            <= v1;
      score_valid_q <= v2;
      for (int r = 0; r < ROWS; r++) row_sum_q[r] <= row_sum_c[r];
      if (v2) score_q <= total_c;
    end
  end

endmodule

// File: tb/tb_ncc_corr_array.sv
// Directed testbench for ncc_corr_array at ROWS=COLS=4, LANES=2, PIX_W=8, ACC_W=16.
module tb_ncc_corr_array;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int PIX_W = 8;
  localparam int LANES = 2;
  localparam int ACC_W = 16;
  localparam int BEATS = ROWS*COLS/LANES;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ncc_corr_array_if #(.ROWS(ROWS), .PIX_W(PIX_W), .LANES(LANES), .ACC_W(ACC_W)) bus ();

  ncc_corr_array #(.ROWS(ROWS), .COLS(COLS), .PIX_W(PIX_W), .LANES(LANES), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int desc_img [ROWS][COLS];
  logic signed [ACC_W-1:0] sq[$];
  int cq[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Score monitor: a handshake seen at a falling edge completes at the next rising edge
  always @(negedge clk) begin
    if (bus.score_valid === 1'b1 && bus.score_ready === 1'b1) begin
      sq.push_back(bus.score);
      cq.push_back(cyc);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [ROWS*PIX_W-1:0] ucol(input int v);
    logic [ROWS*PIX_W-1:0] d;
    for (int r = 0; r < ROWS; r++) d[r*PIX_W +: PIX_W] = PIX_W'(v);
    return d;
  endfunction

  task automatic idle_inputs();
    bus.desc_start  = 1'b0;
    bus.desc_valid  = 1'b0;
    bus.desc_data   = '0;
    bus.win_valid   = 1'b0;
    bus.win_data    = '0;
    bus.score_ready = 1'b1;
  endtask

  task automatic fill_desc(input int v);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) desc_img[r][c] = v;
  endtask

  task automatic clear_scores();
    sq.delete();
    cq.delete();
  endtask

  task automatic pulse_start();
    bus.desc_start = 1'b1;
    @(posedge clk); #1;
    bus.desc_start = 1'b0;
  endtask

  task automatic send_beat(input int b);
    logic [LANES*PIX_W-1:0] d;
    bit ok;
    for (int l = 0; l < LANES; l++)
      d[l*PIX_W +: PIX_W] = PIX_W'(desc_img[b / (COLS/LANES)][(b % (COLS/LANES))*LANES + l]);
    bus.desc_data  = d;
    bus.desc_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus.desc_ready;
      @(posedge clk); #1;
    end
    bus.desc_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL desc_beat_accept: beat %0d not accepted within 20 cycles", b);
    end
  endtask

  task automatic load_desc();
    pulse_start();
    for (int b = 0; b < BEATS-1; b++) send_beat(b);
    checks++;
    if (bus.loaded !== 1'b0) begin
      failures++;
      $display("FAIL loaded_before_last: got %b expected 0", bus.loaded);
    end
    send_beat(BEATS-1);
    checks++;
    if (bus.loaded !== 1'b1) begin
      failures++;
      $display("FAIL loaded_after_last: got %b expected 1", bus.loaded);
    end
  endtask

  task automatic send_col(input logic [ROWS*PIX_W-1:0] d, output int acc_edge);
    bit ok;
    bus.win_data  = d;
    bus.win_valid = 1'b1;
    ok = 1'b0;
    acc_edge = -1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = bus.win_ready;
      if (ok) acc_edge = cyc + 1;
      @(posedge clk); #1;
    end
    bus.win_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL win_accept: column not accepted within 40 cycles");
    end
  endtask

  task automatic wait_scores(input int n, input string name);
    for (int i = 0; i < 40 && sq.size() < n; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (sq.size() != n) begin
      failures++;
      $display("FAIL %s_count: got %0d scores expected %0d", name, sq.size(), n);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.desc_ready !== 1'b0) begin failures++; $display("FAIL reset_desc_ready: got %b expected 0", bus.desc_ready); end
    checks++; if (bus.win_ready !== 1'b0) begin failures++; $display("FAIL reset_win_ready: got %b expected 0", bus.win_ready); end
    checks++; if (bus.score_valid !== 1'b0) begin failures++; $display("FAIL reset_score_valid: got %b expected 0", bus.score_valid); end
    checks++; if (bus.loaded !== 1'b0) begin failures++; $display("FAIL reset_loaded: got %b expected 0", bus.loaded); end
    checks++; if (bus.score !== 16'sd0) begin failures++; $display("FAIL reset_score: got %0d expected 0", bus.score); end
    @(posedge clk); #2;
    rst = 1'b0;
    bus.win_valid  = 1'b1;
    bus.desc_valid = 1'b1;
    @(negedge clk);
    checks++; if (bus.win_ready !== 1'b0) begin failures++; $display("FAIL idle_win_ready: got %b expected 0", bus.win_ready); end
    checks++; if (bus.desc_ready !== 1'b0) begin failures++; $display("FAIL idle_desc_ready: got %b expected 0", bus.desc_ready); end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // Test 1: all-ones descriptor, four columns of 2 give 16*2 = 32, three edges after the 4th accept
  task automatic test_single_score();
    int acc;
    fill_desc(1);
    load_desc();
    bus.desc_valid = 1'b1;
    @(negedge clk);
    checks++; if (bus.desc_ready !== 1'b0) begin failures++; $display("FAIL run_desc_ready: got %b expected 0", bus.desc_ready); end
    @(posedge clk); #1;
    bus.desc_valid = 1'b0;
    clear_scores();
    for (int k = 0; k < COLS; k++) send_col(ucol(2), acc);
    wait_scores(1, "single");
    if (sq.size() >= 1) begin
      checks++; if (sq[0] !== 16'sd32) begin failures++; $display("FAIL single_value: got %0d expected 32", sq[0]); end
      checks++; if (cq[0] != acc + 3) begin failures++; $display("FAIL single_latency: got edge %0d expected %0d", cq[0], acc + 3); end
    end
  endtask

  // Test 2: columns 1..6 -> windows {1..4},{2..5},{3..6} times 4 rows
  task automatic test_sliding();
    int acc;
    int exp_s [3] = '{40, 56, 72};
    fill_desc(1);
    load_desc();
    clear_scores();
    for (int k = 1; k <= 6; k++) send_col(ucol(k), acc);
    wait_scores(3, "sliding");
    if (sq.size() == 3) begin
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (sq[j] !== ACC_W'(exp_s[j])) begin failures++; $display("FAIL sliding_value[%0d]: got %0d expected %0d", j, sq[j], exp_s[j]); end
      end
      checks++; if (cq[1] != cq[0] + 1 || cq[2] != cq[1] + 1) begin failures++; $display("FAIL back_to_back: edges %0d %0d %0d expected consecutive", cq[0], cq[1], cq[2]); end
    end
  endtask

  // Distinct signed descriptor and per-row window values: checks lane/beat mapping and tap pairing
  task automatic test_orientation();
    int acc;
    int e;
    logic signed [ACC_W-1:0] exp_v;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        desc_img[r][c] = (c % 2 == 1) ? -(r*COLS + c + 1) : (r*COLS + c + 1);
    load_desc();
    clear_scores();
    for (int k = 0; k < COLS + 1; k++) begin
      logic [ROWS*PIX_W-1:0] d;
      for (int r = 0; r < ROWS; r++) d[r*PIX_W +: PIX_W] = PIX_W'(10*k + r + 1);
      send_col(d, acc);
    end
    wait_scores(2, "orient");
    if (sq.size() == 2) begin
      for (int j = 0; j < 2; j++) begin
        e = 0;
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) e += desc_img[r][c] * (10*(j + c) + r + 1);
        exp_v = ACC_W'(e);
        checks++;
        if (sq[j] !== exp_v) begin failures++; $display("FAIL orient_value[%0d]: got %0d expected %0d", j, sq[j], exp_v); end
      end
    end
  endtask

  // Test 3: 16 * (-128*255) = -522240, which is 0x0800 modulo 2^16
  task automatic test_wrap();
    int acc;
    fill_desc(-128);
    load_desc();
    clear_scores();
    for (int k = 0; k < COLS; k++) send_col(ucol(255), acc);
    wait_scores(1, "wrap");
    if (sq.size() >= 1) begin
      checks++; if (sq[0] !== 16'sh0800) begin failures++; $display("FAIL wrap_value: got 0x%h expected 0x0800", sq[0]); end
    end
  endtask

  // Test 4: score_ready low for 5 cycles while columns keep coming
  task automatic test_backpressure();
    int k = 0;
    int stall_seen = 0;
    bit acc;
    bit held_set = 1'b0;
    logic signed [ACC_W-1:0] held = '0;
    int exp_s [5] = '{40, 56, 72, 88, 104};
    fill_desc(1);
    load_desc();
    clear_scores();
    for (int i = 0; i < 40; i++) begin
      bus.score_ready = !(i >= 7 && i < 12);
      bus.win_valid   = (k < 8);
      bus.win_data    = ucol(k + 1);
      @(negedge clk);
      if (bus.score_valid && !bus.score_ready) begin
        stall_seen++;
        checks++;
        if (bus.win_ready !== 1'b0) begin failures++; $display("FAIL stall_win_ready: got %b expected 0", bus.win_ready); end
        if (held_set) begin
          checks++;
          if (bus.score !== held) begin failures++; $display("FAIL stall_score_hold: got %0d expected %0d", bus.score, held); end
        end else begin
          held = bus.score;
          held_set = 1'b1;
        end
      end
      acc = bus.win_valid && bus.win_ready;
      @(posedge clk); #1;
      if (acc) k++;
    end
    idle_inputs();
    checks++;
    if (stall_seen < 5) begin failures++; $display("FAIL stall_observed: got %0d stalled cycles expected 5", stall_seen); end
    wait_scores(5, "backpressure");
    if (sq.size() == 5) begin
      for (int j = 0; j < 5; j++) begin
        checks++;
        if (sq[j] !== ACC_W'(exp_s[j])) begin failures++; $display("FAIL bp_value[%0d]: got %0d expected %0d", j, sq[j], exp_s[j]); end
      end
    end
  endtask

  // Test 5: abandoned partial load, then a full reload with descriptor 3 -> 16*3*2 = 96
  task automatic test_reload();
    int acc;
    fill_desc(7);
    pulse_start();
    for (int b = 0; b < 3; b++) send_beat(b);
    checks++; if (bus.loaded !== 1'b0) begin failures++; $display("FAIL partial_loaded: got %b expected 0", bus.loaded); end
    fill_desc(3);
    load_desc();
    clear_scores();
    for (int k = 0; k < COLS; k++) send_col(ucol(2), acc);
    wait_scores(1, "reload");
    if (sq.size() >= 1) begin
      checks++; if (sq[0] !== 16'sd96) begin failures++; $display("FAIL reload_value: got %0d expected 96", sq[0]); end
    end
  endtask

  // Test 6: asynchronous reset while a score is pending
  task automatic test_rst_mid_run();
    int acc;
    int ready_seen = 0;
    clear_scores();
    bus.score_ready = 1'b0;
    send_col(ucol(4), acc);
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.score_valid !== 1'b1) begin failures++; $display("FAIL pre_rst_score_valid: got %b expected 1", bus.score_valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.score_valid !== 1'b0) begin failures++; $display("FAIL rst_score_valid: got %b expected 0", bus.score_valid); end
    checks++; if (bus.loaded !== 1'b0) begin failures++; $display("FAIL rst_loaded: got %b expected 0", bus.loaded); end
    @(posedge clk); #3;
    rst = 1'b0;
    bus.score_ready = 1'b1;
    bus.win_valid   = 1'b1;
    bus.win_data    = ucol(9);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.win_ready !== 1'b0) ready_seen++;
    end
    @(posedge clk); #1;
    idle_inputs();
    checks++; if (ready_seen != 0) begin failures++; $display("FAIL post_rst_win_ready: got %0d ready cycles expected 0", ready_seen); end
    checks++; if (sq.size() != 0) begin failures++; $display("FAIL post_rst_scores: got %0d scores expected 0", sq.size()); end
    fill_desc(1);
    load_desc();
    clear_scores();
    for (int k = 0; k < COLS; k++) send_col(ucol(2), acc);
    wait_scores(1, "recover");
    if (sq.size() >= 1) begin
      checks++; if (sq[0] !== 16'sd32) begin failures++; $display("FAIL recover_value: got %0d expected 32", sq[0]); end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_score();
    test_sliding();
    test_orientation();
    test_wrap();
    test_backpressure();
    test_reload();
    test_rst_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
